// File: rtl/hwpe_stream_addressgen_v5.sv
// Multi-dimensional strided address generator with a valid/ready address stream.
// Per-dimension offsets are accumulated incrementally, so no multipliers are needed.
module hwpe_stream_addressgen_v5 #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned TRANS_CNT  = 32,
    parameter int unsigned CNT        = 32,
    parameter int          DIMENSIONS = 3
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  enable_i,
    input  logic                                  clear_i,
    input  logic                                  start_i,
    input  logic [ADDR_W-1:0]                     base_addr_i,
    input  logic [TRANS_CNT-1:0]                  tot_len_i,
    input  logic [DIMENSIONS-1:0]                 dim_en_i,
    input  logic [DIMENSIONS-1:0][CNT-1:0]        dim_len_i,
    input  logic [DIMENSIONS-1:0][ADDR_W-1:0]     dim_stride_i,
    output logic                                  addr_valid_o,
    input  logic                                  addr_ready_i,
    output logic [ADDR_W-1:0]                     addr_data_o,
    output logic [DIMENSIONS-1:0]                 addr_last_o,
    output logic                                  addr_end_o,
    output logic                                  busy_o,
    output logic                                  done_o
);

    // state | meaning
    // IDLE  | waiting for start_i, configuration not yet latched
    // RUN   | emitting addresses, one per handshake
    // DONE  | one-cycle completion pulse on done_o, then back to IDLE

    generate
        if (DIMENSIONS < 1) begin : g_bad_dimensions
            $fatal(1, "hwpe_stream_addressgen_v5: DIMENSIONS must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                              state;
    logic [ADDR_W-1:0]                   cfg_base;
    logic [TRANS_CNT-1:0]                cfg_tot;
    logic [DIMENSIONS-1:0]               cfg_en;
    logic [DIMENSIONS-1:0][CNT-1:0]      cfg_len;
    logic [DIMENSIONS-1:0][ADDR_W-1:0]   cfg_stride;

    logic [DIMENSIONS-1:0][CNT-1:0]      idx, idx_n;
    logic [DIMENSIONS-1:0][ADDR_W-1:0]   acc, acc_n;
    logic [TRANS_CNT-1:0]                cnt;
    logic                                valid, busy, done;

    logic [DIMENSIONS-1:0][CNT-1:0]      len_m1;
    logic [DIMENSIONS-1:0]               at_last, last_vec;
    logic                                hs, is_end, carry, last_run;
    logic [ADDR_W-1:0]                   addr_sum;

    // Carry ripples from dim 0 upwards; disabled dims count as at-last so carries pass through.
    always_comb begin
        hs       = valid & addr_ready_i & enable_i;
        carry    = hs;
        last_run = 1'b1;
        idx_n    = idx;
        acc_n    = acc;
        len_m1   = '0;
        at_last  = '0;
        last_vec = '0;
        addr_sum = cfg_base;
        for (int i = 0; i < DIMENSIONS; i++) begin
            len_m1[i]  = (cfg_len[i] == '0) ? '0 : cfg_len[i] - 1'b1;
            at_last[i] = ~cfg_en[i] | (idx[i] == len_m1[i]);
            if (carry && cfg_en[i]) begin
                idx_n[i] = at_last[i] ? '0 : idx[i] + 1'b1;
                acc_n[i] = at_last[i] ? '0 : acc[i] + cfg_stride[i];
            end
            carry       = carry & at_last[i];
            last_run    = last_run & at_last[i];
            last_vec[i] = last_run;
            addr_sum    = addr_sum + acc[i];
        end
        is_end = (cnt == cfg_tot - 1'b1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cfg_base   <= '0;
            cfg_tot    <= '0;
            cfg_en     <= '0;
            cfg_len    <= '0;
            cfg_stride <= '0;
            idx        <= '0;
            acc        <= '0;
            cnt        <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (clear_i) begin
            state <= IDLE;
            idx   <= '0;
            acc   <= '0;
            cnt   <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start_i) begin
                        cfg_base   <= base_addr_i;
                        cfg_tot    <= tot_len_i;
                        cfg_en     <= dim_en_i;
                        cfg_len    <= dim_len_i;
                        cfg_stride <= dim_stride_i;
                        idx        <= '0;
                        acc        <= '0;
                        cnt        <= '0;
                        if (tot_len_i != '0) begin
                            state <= RUN;
                            valid <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (is_end) begin
                            state <= DONE;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                            idx <= idx_n;
                            acc <= acc_n;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_valid_o = valid;
    assign busy_o       = busy;
    assign done_o       = done;
    assign addr_data_o  = valid ? addr_sum : '0;
    assign addr_last_o  = valid ? last_vec : '0;
    assign addr_end_o   = valid & is_end;

endmodule

// File: doc/hwpe_stream_addressgen_v5.md
HWPE_STREAM_ADDRESSGEN_V5 -- requirements
Module: hwpe_stream_addressgen_v5

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address and stride width in bits.
REQ-002 SHALL have parameter TRANS_CNT, default 32: transaction counter width.
REQ-003 SHALL have parameter CNT, default 32: per-dimension counter width.
REQ-004 SHALL have parameter DIMENSIONS, default 3: number of dimensions; elaboration SHALL fail fatally if DIMENSIONS < 1.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port enable_i, input, 1 bit: global advance enable.
REQ-008 SHALL have port clear_i, input, 1 bit: synchronous abort to IDLE.
REQ-009 SHALL have port start_i, input, 1 bit: single-cycle start pulse.
REQ-010 SHALL have port base_addr_i, input, ADDR_W bits: byte base address.
REQ-011 SHALL have port tot_len_i, input, TRANS_CNT bits: total number of addresses to emit.
REQ-012 SHALL have port dim_en_i, input, DIMENSIONS bits: per-dimension enable.
REQ-013 SHALL have port dim_len_i, input, DIMENSIONS x CNT bits: steps per dimension.
REQ-014 SHALL have port dim_stride_i, input, DIMENSIONS x ADDR_W bits: signed two's-complement byte stride.
REQ-015 SHALL have port addr_valid_o, output, 1 bit: address stream valid.
REQ-016 SHALL have port addr_ready_i, input, 1 bit: address stream ready.
REQ-017 SHALL have port addr_data_o, output, ADDR_W bits: address.
REQ-018 SHALL have port addr_last_o, output, DIMENSIONS bits: per-dimension sweep-end flag.
REQ-019 SHALL have port addr_end_o, output, 1 bit: final address of the run.
REQ-020 SHALL have port busy_o, output, 1 bit: high in RUN.
REQ-021 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-022 SHALL implement FSM states IDLE, RUN, DONE, with IDLE as the reset state.
REQ-023 SHALL, in IDLE with start_i=1, latch all configuration inputs into internal registers; later changes to those inputs SHALL NOT affect the run.
REQ-024 SHALL, on start at cycle t with tot_len_i > 0, enter RUN and present addr_valid_o=1 with addr_data_o=base_addr_i at cycle t+1.
REQ-025 SHALL, on start with tot_len_i=0, go to DONE, never assert valid, and assert done_o at t+1.
REQ-026 SHALL define a handshake as addr_valid_o & addr_ready_i & enable_i; state and counters SHALL advance only on a handshake.
REQ-027 SHALL, while valid and no handshake occurs, hold addr_data_o, addr_last_o and addr_end_o stable and keep valid high.
REQ-028 SHALL sustain one address per cycle under continuous handshakes.
REQ-029 SHALL maintain index idx[i] from 0 to L[i]-1, where L[i] = max(dim_len[i], 1); dimension 0 SHALL step on every handshake.
REQ-030 SHALL, when dimension i is at L[i]-1, wrap it to 0 and carry into the next enabled dimension; the highest enabled dimension SHALL wrap so the pattern repeats.
REQ-031 SHALL hold a disabled dimension at idx 0 with zero contribution, and pass carries through it unchanged.
REQ-032 SHALL compute address = base + sum(idx[i]*stride[i]) mod 2^ADDR_W, using incremental per-dimension offset accumulators with no multipliers.
REQ-033 SHALL let the address wrap silently on overflow or underflow.
REQ-034 SHALL assert addr_last_o[i] when every enabled j <= i satisfies idx[j] = L[j]-1; disabled dimensions count as at-last.
REQ-035 SHALL assert addr_end_o on the beat whose transaction count equals tot_len-1.
REQ-036 SHALL, on the handshake of the addr_end_o beat, drop valid at the next cycle, enter DONE and assert done_o for exactly 1 cycle, then return to IDLE.
REQ-037 SHALL ignore start_i outside IDLE.
REQ-038 SHALL, on clear_i in any state, return to IDLE at the next edge with counters and accumulators at 0, valid 0 and no done_o; clear_i SHALL take priority over start_i and handshakes.
REQ-039 SHALL gate only handshakes with enable_i=0; clear_i and start_i SHALL still act.

Reset
REQ-040 SHALL, asynchronously on rst_ni=0, force FSM=IDLE, all counters and accumulators to 0, and set addr_valid_o, addr_data_o, addr_last_o, addr_end_o, busy_o and done_o to 0.
REQ-041 SHALL, when reset asserts mid-run, return to the state of REQ-040 immediately; no done_o SHALL follow release.

Verification
REQ-042 SHALL verify basic run: base 0x1000, len {3,2}, stride {4,0x100}, dim2 disabled, tot_len 6, ready=1 -> 0x1000,0x1004,0x1008,0x1100,0x1104,0x1108; last[0] on beats 2,5; last[1] on beat 5; end on beat 5; done_o one cycle later.
REQ-043 SHALL verify backpressure: same setup with ready toggling 1,0,1,0 -> identical sequence, data stable while stalled, valid never drops before end.
REQ-044 SHALL verify negative stride and repeat: base 0x2000, dim0 only, len 4, stride 0xFFFFFFF8, tot_len 6 -> 0x2000,0x1FF8,0x1FF0,0x1FE8,0x2000,0x1FF8.
REQ-045 SHALL verify the zero-length run: tot_len 0 -> valid stays 0, done_o=1 at t+1 for 1 cycle.
REQ-046 SHALL verify clear mid-run: clear after beat 2 -> valid 0, busy 0 next cycle, no done_o; a new start restarts at base.
REQ-047 SHALL verify address wrap: base 0xFFFFFFFC, stride 8, tot_len 2 -> 0xFFFFFFFC, 0x00000004.
